// File: rtl/data_mem_unit.sv
`timescale 1ns/1ps
// data_mem_unit: MEM-stage data memory with RV32I byte/half/word access,
// a registered one-cycle load response, fault reporting and a pipeline hold.
module data_mem_unit #(
  parameter int ADDR_BITS   = 8,
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        rsp_valid,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Word storage; contents are deliberately not reset.
  logic [31:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           byte_off;
  logic                 accept;
  logic                 f3_ok;
  logic                 misaligned;
  logic                 upper_nz;
  logic                 out_of_range;
  logic                 illegal;
  logic                 do_load;
  logic                 do_store;
  logic [3:0]           lane_en;
  logic [31:0]          lane_data;
  logic [31:0]          rd_word;

  logic [31:0] read_data_d,  read_data_q;
  logic        rsp_valid_d,  rsp_valid_q;
  logic        fault_d,      fault_q;
  logic [31:0] fault_addr_d, fault_addr_q;

  // Pick the addressed byte or half out of a word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [31:0] word,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b010:  load_extend = word;
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = 32'd0;
    endcase
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_lanes(input logic [2:0] f3,
                                             input logic [1:0] off);
    case (f3)
      3'b000:  store_lanes = 4'b0001 << off;
      3'b001:  store_lanes = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  store_lanes = 4'b1111;
      default: store_lanes = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] store_align(input logic [2:0]  f3,
                                              input logic [31:0] wd);
    case (f3)
      3'b000:  store_align = {4{wd[7:0]}};
      3'b001:  store_align = {2{wd[15:0]}};
      default: store_align = wd;
    endcase
  endfunction

  assign word_idx = addr[ADDR_BITS+1:2];
  assign byte_off = addr[1:0];
  assign accept   = !hold && (mem_read || mem_write);
  assign upper_nz = (addr >> (ADDR_BITS + 2)) != 32'd0;
  assign rd_word  = mem[word_idx];

  // Classify the request: legal funct3 for its direction, alignment, range.
  always_comb begin
    f3_ok = 1'b0;
    if (mem_read && !mem_write) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else if (mem_write && !mem_read) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (CHECK_RANGE != 0) && upper_nz;
    illegal      = !f3_ok || misaligned || out_of_range;
    do_load      = accept && !illegal && mem_read;
    do_store     = accept && !illegal && mem_write && !rst;
    lane_en      = store_lanes(funct3, byte_off);
    lane_data    = store_align(funct3, write_data);
  end

  // Byte-lane store; reset in the same cycle cancels the write.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  // Next response: frozen under hold, otherwise a fault pulse, a load result, or idle zeros.
  always_comb begin
    read_data_d  = read_data_q;
    rsp_valid_d  = rsp_valid_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (!hold) begin
      read_data_d = 32'd0;
      rsp_valid_d = 1'b0;
      fault_d     = 1'b0;
      if (accept && illegal) begin
        fault_d      = 1'b1;
        fault_addr_d = addr;
      end else if (do_load) begin
        rsp_valid_d = 1'b1;
        read_data_d = load_extend(funct3, rd_word, byte_off);
      end
    end
  end

  // Response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q  <= 32'd0;
      rsp_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      read_data_q  <= read_data_d;
      rsp_valid_q  <= rsp_valid_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign read_data  = read_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
`timescale 1ns/1ps
// tb_data_mem_unit: directed test-plan sequences plus randomized traffic,
// checked every cycle against a byte-addressed behavioural model.
module tb_data_mem_unit;

  localparam int AB   = 8;
  localparam int MEMB = 4 * (2 ** AB);

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        rsp_valid;
  logic        fault;
  logic [31:0] fault_addr;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: byte memory and expected outputs after each edge.
  logic [7:0]  mb [MEMB];
  logic [31:0] e_rd  = 32'd0;
  logic [31:0] e_fa  = 32'd0;
  logic        e_vld = 1'b0;
  logic        e_flt = 1'b0;

  data_mem_unit #(.ADDR_BITS(AB), .CHECK_RANGE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .rsp_valid  (rsp_valid),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: size/legality from funct3 and address arithmetic.
  always @(posedge clk) begin
    int    sz;
    bit    bad;
    int    ba;
    longint val;
    if (rst) begin
      e_rd = 32'd0; e_vld = 1'b0; e_flt = 1'b0; e_fa = 32'd0;
    end else if (!hold) begin
      e_rd = 32'd0; e_vld = 1'b0; e_flt = 1'b0;
      if (mem_read || mem_write) begin
        case (funct3)
          3'b000, 3'b100: sz = 1;
          3'b001, 3'b101: sz = 2;
          3'b010:         sz = 4;
          default:        sz = 0;
        endcase
        bad = (mem_read && mem_write) || (sz == 0) || (mem_write && funct3[2]) ||
              (addr >= 32'(MEMB));
        if (!bad && (addr % 32'(sz)) != 32'd0) bad = 1'b1;
        if (bad) begin
          e_flt = 1'b1;
          e_fa  = addr;
        end else begin
          ba = int'(addr);
          if (mem_write) begin
            for (int i = 0; i < sz; i++) mb[ba+i] = write_data[8*i +: 8];
          end else begin
            val = 0;
            for (int i = sz - 1; i >= 0; i--) val = val * 256 + longint'(mb[ba+i]);
            if (!funct3[2] && sz < 4 && val >= (longint'(1) << (8*sz - 1)))
              val = val - (longint'(1) << (8*sz));
            e_rd  = 32'(val);
            e_vld = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("read_data", read_data, e_rd);
    chk("rsp_valid", 32'(rsp_valid), 32'(e_vld));
    chk("fault", 32'(fault), 32'(e_flt));
    if (e_flt) chk("fault_addr", fault_addr, e_fa);
  end

  task automatic step(input logic r, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic h, input logic rs);
    @(negedge clk);
    mem_read = r; mem_write = w; funct3 = f; addr = a;
    write_data = wd; hold = h; rst = rs;
  endtask

  task automatic ld(input logic [2:0] f, input logic [31:0] a);
    step(1'b1, 1'b0, f, a, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic st(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, f, a, wd, 1'b0, 1'b0);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int          op;
    logic [2:0]  f;
    logic [31:0] a;
    logic        r, w, h, rs;
    int          pick;

    rst = 1'b1; hold = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'd0; write_data = 32'd0;
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1);
    settle;
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_fault_addr", fault_addr, 32'd0);

    // Give every word a known value.
    for (int i = 0; i < MEMB / 4; i++) st(3'b010, 32'(4 * i), $urandom);

    st(3'b010, 32'h10, 32'h8000_00F1);
    ld(3'b010, 32'h10); settle;
    chk("lw10_valid", 32'(rsp_valid), 32'd1);
    chk("lw10_data", read_data, 32'h8000_00F1);

    st(3'b010, 32'h20, 32'h1122_3344);
    st(3'b000, 32'h21, 32'h0000_00AA);
    ld(3'b000, 32'h21); settle; chk("lb21", read_data, 32'hFFFF_FFAA);
    ld(3'b100, 32'h21); settle; chk("lbu21", read_data, 32'h0000_00AA);
    ld(3'b010, 32'h20); settle; chk("lw20_lanes", read_data, 32'h1122_AA44);

    st(3'b001, 32'h32, 32'h0000_8001);
    ld(3'b001, 32'h32); settle; chk("lh32", read_data, 32'hFFFF_8001);
    ld(3'b101, 32'h32); settle; chk("lhu32", read_data, 32'h0000_8001);
    ld(3'b001, 32'h31); settle;
    chk("lh31_fault", 32'(fault), 32'd1);
    chk("lh31_fault_addr", fault_addr, 32'h31);
    chk("lh31_valid", 32'(rsp_valid), 32'd0);

    st(3'b010, 32'h40, 32'h1234_5678);
    st(3'b010, 32'h42, 32'hFFFF_FFFF); settle;
    chk("sw42_fault", 32'(fault), 32'd1);
    ld(3'b010, 32'h40); settle; chk("lw40_after_bad_sw", read_data, 32'h1234_5678);
    step(1'b1, 1'b1, 3'b010, 32'h40, 32'h0, 1'b0, 1'b0); settle;
    chk("rdwr_fault", 32'(fault), 32'd1);
    ld(3'b010, 32'h40); settle; chk("lw40_after_rdwr", read_data, 32'h1234_5678);
    ld(3'b010, 32'h400); settle;
    chk("lw400_fault", 32'(fault), 32'd1);
    chk("lw400_valid", 32'(rsp_valid), 32'd0);

    st(3'b010, 32'h14, 32'h0000_0005);
    ld(3'b010, 32'h14); settle; chk("lw14", read_data, 32'h5);
    repeat (3) begin
      step(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b1, 1'b0); settle;
      chk("hold_read_data", read_data, 32'h5);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    ld(3'b010, 32'h10); settle; chk("lw10_after_hold", read_data, 32'h8000_00F1);

    st(3'b010, 32'h50, 32'hCAFE_F00D);
    ld(3'b010, 32'h50); settle; chk("lw50_pre", read_data, 32'hCAFE_F00D);
    step(1'b0, 1'b1, 3'b010, 32'h50, 32'hDEAD_BEEF, 1'b0, 1'b1); settle;
    chk("rst_sw_read_data", read_data, 32'd0);
    chk("rst_sw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sw_fault", 32'(fault), 32'd0);
    chk("rst_sw_fault_addr", fault_addr, 32'd0);
    ld(3'b010, 32'h50); settle; chk("lw50_post_rst", read_data, 32'hCAFE_F00D);

    // Randomized traffic, concentrated on a small window for store/load reuse.
    for (int k = 0; k < 3000; k++) begin
      op = $urandom_range(0, 9);
      r  = (op >= 2 && op <= 5) || op == 9;
      w  = (op >= 6);
      if ($urandom_range(0, 4) == 0) begin
        f = 3'($urandom);
      end else if (w && !r) begin
        f = 3'($urandom_range(0, 2));
      end else begin
        pick = $urandom_range(0, 4);
        f = (pick >= 3) ? 3'(pick + 1) : 3'(pick);
      end
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1, 2, 3: a = 32'($urandom_range(0, MEMB - 1));
        default: a = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f[1:0] == 2'b01) a[0] = 1'b0;
      end
      h  = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(r, w, f, a, $urandom, h, rs);
    end

    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    settle;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
